// File: rtl/jk_pkg.sv
// Shared types and the JK cell transfer function for the modulo counter.
package jk_pkg;

  // Per-cell command, encoded as {j, k}.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  // Counter-level operation selected each cycle, already priority-resolved.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } jk_op_t;

  // Next state of one JK cell; 11 always toggles, there is no undefined case.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case (jk_cmd_t'({j, k}))
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell_ar.sv
// Single JK storage cell with asynchronous active-low reset to 0.
module jk_cell_ar
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // Cell state: cleared by reset, otherwise follows the JK transfer function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= jk_next(q_q, j, k);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a row of JK cells. The excitation
// stage turns clr/load/count commands into per-bit J/K, which are exported
// so cell-level behaviour can be observed.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  jk_op_t           op;
  logic [WIDTH-1:0] tgt_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] cell_q;
  logic             wrap_q;

  // Resolve the command priority: clr, then load, then count, else hold.
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_INC : OP_DEC;
    end
  end

  // Target count for this edge. Loads clamp rather than wrap; an
  // out-of-range count heading up returns to 0 via the >= compare.
  always_comb begin
    tgt_d = cell_q;
    case (op)
      OP_CLR:  tgt_d = '0;
      OP_LOAD: tgt_d = (d > MAX_VAL) ? MAX_VAL : d;
      OP_INC:  tgt_d = (cell_q >= MAX_VAL) ? '0 : cell_q + WIDTH'(1);
      OP_DEC:  tgt_d = (cell_q == '0) ? MAX_VAL : cell_q - WIDTH'(1);
      default: tgt_d = cell_q;
    endcase
  end

  // Excitation: clr resets every cell, load forces set/reset per bit, and
  // counting toggles only the bits that must change.
  always_comb begin
    j_d = '0;
    k_d = '0;
    case (op)
      OP_CLR: begin
        j_d = '0;
        k_d = '1;
      end
      OP_LOAD: begin
        j_d = tgt_d;
        k_d = ~tgt_d;
      end
      OP_INC, OP_DEC: begin
        j_d = tgt_d ^ cell_q;
        k_d = tgt_d ^ cell_q;
      end
      default: begin
        j_d = '0;
        k_d = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell_ar u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j_d[i]),
      .k    (k_d[i]),
      .q    (cell_q[i])
    );
  end

  // Terminal count compares against MODULUS-1, never against WIDTH overflow.
  assign tc = ((op == OP_INC) && (cell_q == MAX_VAL)) ||
              ((op == OP_DEC) && (cell_q == '0));

  // Wrap flag: one-cycle echo of tc, held while tc stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign q     = cell_q;
  assign wrap  = wrap_q;
  assign j_vec = j_d;
  assign k_vec = k_d;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: directed scenarios on a mod-10 instance, a
// random run shared with a mod-16 instance, and an arithmetic reference
// model checked against both instances every cycle.
module tb_jk_mod_counter;
  import jk_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] d;
  logic       en;
  logic       up;

  logic [3:0] q10, j10, k10;
  logic       tc10, wrap10;
  logic [3:0] q16, j16, k16;
  logic       tc16, wrap16;

  int total = 0;
  int bad   = 0;

  int mq10, mq16;
  bit mw10, mw16;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q10), .tc(tc10), .wrap(wrap10), .j_vec(j10), .k_vec(k10)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q16), .tc(tc16), .wrap(wrap16), .j_vec(j16), .k_vec(k16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference next count from the command rules, in plain integers.
  function automatic int m_next(int qv, int m, bit c, bit l, int dv, bit e, bit u);
    if (c) return 0;
    if (l) return (dv > m - 1) ? m - 1 : dv;
    if (e && u) return (qv >= m - 1) ? 0 : qv + 1;
    if (e) return (qv == 0) ? m - 1 : qv - 1;
    return qv;
  endfunction

  function automatic bit m_tc(int qv, int m, bit c, bit l, bit e, bit u);
    return e && !c && !l && ((u && qv == m - 1) || (!u && qv == 0));
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq10 <= 0;
      mq16 <= 0;
      mw10 <= 1'b0;
      mw16 <= 1'b0;
    end else begin
      mw10 <= m_tc(mq10, 10, clr, load, en, up);
      mw16 <= m_tc(mq16, 16, clr, load, en, up);
      mq10 <= m_next(mq10, 10, clr, load, int'(d), en, up);
      mq16 <= m_next(mq16, 16, clr, load, int'(d), en, up);
    end
  end

  task automatic cmp_dut(input string nm, input int m, input int mq, input bit mw,
                         input logic [3:0] aq, input logic atc, input logic aw,
                         input logic [3:0] aj, input logic [3:0] ak);
    logic [3:0] t4, ej, ek, mq4;
    bit inv;
    t4  = 4'(m_next(mq, m, clr, load, int'(d), en, up));
    mq4 = 4'(mq);
    if (clr) begin
      ej = 4'h0; ek = 4'hF;
    end else if (load) begin
      ej = t4; ek = ~t4;
    end else if (en) begin
      ej = t4 ^ mq4; ek = t4 ^ mq4;
    end else begin
      ej = 4'h0; ek = 4'h0;
    end
    inv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (jk_next(aq[i], aj[i], ak[i]) !== t4[i]) inv = 1'b0;
    end
    chk({nm, ".nox"}, 32'($isunknown({aq, atc, aw, aj, ak})), 32'd0);
    chk({nm, ".q"}, 32'(aq), 32'(mq));
    chk({nm, ".tc"}, 32'(atc), 32'(m_tc(mq, m, clr, load, en, up)));
    chk({nm, ".wrap"}, 32'(aw), 32'(mw));
    chk({nm, ".j"}, 32'(aj), 32'(ej));
    chk({nm, ".k"}, 32'(ak), 32'(ek));
    chk({nm, ".jk_invariant"}, 32'(inv), 32'd1);
  endtask

  // Every negedge both instances are compared against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("m10", 10, mq10, mw10, q10, tc10, wrap10, j10, k10);
      cmp_dut("m16", 16, mq16, mw16, q16, tc16, wrap16, j16, k16);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; d = 4'h0; en = 1'b0; up = 1'b0;
    #3;
    chk("rst.q", 32'(q10), 32'd0);
    chk("rst.wrap", 32'(wrap10), 32'd0);
    tick();
    rst_n = 1'b1;

    // Count up through the 9 -> 0 wrap.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("up.q", 32'(q10), 32'(exp_up[i]));
      if (exp_up[i] == 9) begin
        chk("up.tc_at9", 32'(tc10), 32'd1);
        chk("up.j_at9", 32'(j10), 32'b1001);
        chk("up.k_at9", 32'(k10), 32'b1001);
      end
      if (exp_up[i] == 0) chk("up.wrap_at0", 32'(wrap10), 32'd1);
      if (i == 10) chk("up.wrap_gone", 32'(wrap10), 32'd0);
    end

    // Clear, then count down through 0 -> 9.
    tick();
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b0;
    @(negedge clk);
    chk("dn.q0", 32'(q10), 32'd0);
    chk("dn.tc_at0", 32'(tc10), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("dn.q9", 32'(q10), 32'd9);
    chk("dn.wrap", 32'(wrap10), 32'd1);
    chk("dn.j_9to8", 32'(j10), 32'b0001);
    chk("dn.k_9to8", 32'(k10), 32'b0001);
    @(posedge clk);
    @(negedge clk);
    chk("dn.q8", 32'(q10), 32'd8);
    chk("dn.wrap_gone", 32'(wrap10), 32'd0);

    // Clamped load, then load beats count.
    tick();
    en = 1'b0; load = 1'b1; d = 4'd13;
    @(negedge clk);
    chk("ld.j13", 32'(j10), 32'b1001);
    chk("ld.k13", 32'(k10), 32'b0110);
    tick();
    d = 4'd5; en = 1'b1; up = 1'b1;
    @(negedge clk);
    chk("ld.q_clamped", 32'(q10), 32'd9);
    chk("ld.tc_suppressed", 32'(tc10), 32'd0);
    tick();
    load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("ld.q5", 32'(q10), 32'd5);

    // clr + load + en at q=9 counting up: clr wins, no wrap.
    tick();
    load = 1'b1; d = 4'd9;
    tick();
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd3;
    @(negedge clk);
    chk("all.q9", 32'(q10), 32'd9);
    chk("all.tc", 32'(tc10), 32'd0);
    tick();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("all.q0", 32'(q10), 32'd0);
    chk("all.wrap", 32'(wrap10), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold.q", 32'(q10), 32'd0);
      chk("hold.j", 32'(j10), 32'd0);
      chk("hold.k", 32'(k10), 32'd0);
    end

    // Asynchronous reset in the middle of a cycle at q=7.
    tick();
    en = 1'b1; up = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    chk("arst.q_before", 32'(q10), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("arst.q", 32'(q10), 32'd0);
    chk("arst.wrap", 32'(wrap10), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arst.resume", 32'(q10), 32'd1);

    // Random commands, checked against the model on both instances.
    for (int n = 0; n < 10000; n++) begin
      tick();
      clr  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      d    = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
